// File: rtl/pll_node_ctrl.sv
// ADPLL node control core: weighted neighbour-error combiner, PI loop filter,
// DCO code / frequency-select generation, mode handling and lock detection.
module pll_node_ctrl #(
  parameter int unsigned NUM_NEIGHBOURS = 4,
  parameter int unsigned ERROR_WIDTH    = 5,
  parameter int unsigned WEIGHT_WIDTH   = 4,
  parameter int unsigned KP_WIDTH       = 6,
  parameter int unsigned KI_WIDTH       = 8,
  parameter int unsigned FRAC_WIDTH     = 5,
  parameter int unsigned ACC_WIDTH      = 16,
  parameter int unsigned DCO_CC_WIDTH   = 5,
  parameter int unsigned BIAS           = 15,
  parameter int unsigned LOCK_THRESH    = 1,
  parameter int unsigned LOCK_COUNT     = 16
) (
  input  logic                                     fpga_clk_i,
  input  logic                                     reset_i,
  input  logic                                     enable_i,
  input  logic                                     update_i,
  input  logic [NUM_NEIGHBOURS*ERROR_WIDTH-1:0]    errors_i,
  input  logic [NUM_NEIGHBOURS*WEIGHT_WIDTH-1:0]   weights_i,
  input  logic [KP_WIDTH-1:0]                      kp_i,
  input  logic [KI_WIDTH-1:0]                      ki_i,
  input  logic [1:0]                               mode_i,
  input  logic [DCO_CC_WIDTH-1:0]                  manual_cc_i,
  output logic [ERROR_WIDTH-1:0]                   error_comb_o,
  output logic [DCO_CC_WIDTH-1:0]                  dco_cc_o,
  output logic [DCO_CC_WIDTH-1:0]                  f_sel_o,
  output logic                                     valid_o,
  output logic                                     locked_o
);

  localparam int unsigned PROD_W = ERROR_WIDTH + WEIGHT_WIDTH + 1;
  localparam int unsigned SUM_W  = PROD_W + $clog2(NUM_NEIGHBOURS) + 1;
  localparam int unsigned INT_W  = ACC_WIDTH + KI_WIDTH + KP_WIDTH + ERROR_WIDTH + 2;
  localparam int unsigned ABS_W  = ERROR_WIDTH + 1;
  localparam int unsigned CNT_W  = $clog2(LOCK_COUNT + 1);

  localparam logic signed [SUM_W-1:0] ERR_MAX = SUM_W'((64'sd1 <<< (ERROR_WIDTH - 1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] ERR_MIN = -ERR_MAX - SUM_W'(1);
  localparam logic signed [INT_W-1:0] ACC_MAX = INT_W'((64'sd1 <<< (ACC_WIDTH - 1)) - 64'sd1);
  localparam logic signed [INT_W-1:0] ACC_MIN = -ACC_MAX;
  localparam logic signed [INT_W-1:0] DCO_MAX = INT_W'((64'sd1 <<< (DCO_CC_WIDTH - 1)) - 64'sd1);
  localparam logic signed [INT_W-1:0] DCO_MIN = -DCO_MAX - INT_W'(1);
  localparam logic signed [INT_W-1:0] FS_MAX  = INT_W'((64'sd1 <<< DCO_CC_WIDTH) - 64'sd1);
  localparam logic signed [INT_W-1:0] FS_MIN  = '0;
  localparam logic signed [INT_W-1:0] BIAS_W  = INT_W'(BIAS);
  localparam logic [ABS_W-1:0]        TH_IN   = ABS_W'(LOCK_THRESH);
  localparam logic [ABS_W-1:0]        TH_OUT  = ABS_W'(2 * LOCK_THRESH);
  localparam logic [CNT_W-1:0]        CNT_MAX = CNT_W'(LOCK_COUNT);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ACQUIRE = 3'd1;
  localparam logic [2:0] ST_LOCKED  = 3'd2;
  localparam logic [2:0] ST_MANUAL  = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;

  logic [2:0]                      state_q, state_d;
  logic                            accept_c;
  logic signed [SUM_W-1:0]         sum_c, shift_c, wgt_k;
  logic signed [ERROR_WIDTH-1:0]   err_k, comb_c;

  logic                            s1_valid_q;
  logic [1:0]                      s1_mode_q;
  logic [KP_WIDTH-1:0]             s1_kp_q;
  logic [KI_WIDTH-1:0]             s1_ki_q;
  logic signed [DCO_CC_WIDTH-1:0]  s1_man_q;
  logic signed [ERROR_WIDTH-1:0]   error_comb_q;

  logic signed [ACC_WIDTH-1:0]     integ_q, integ_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d, cnt_n;
  logic signed [DCO_CC_WIDTH-1:0]  dco_q, dco_d;
  logic [DCO_CC_WIDTH-1:0]         fsel_q, fsel_d;
  logic                            valid_q, valid_d;
  logic                            locked_q, locked_d;

  logic signed [INT_W-1:0]         e_w, integ_sum, integ_new, out_w, out_sh, dco_w, man_w;
  logic signed [ABS_W-1:0]         e_ext;
  logic [ABS_W-1:0]                abs_e;

  // Maps a signed DCO code onto the clamped, biased ring-oscillator select
  function automatic logic [DCO_CC_WIDTH-1:0] fsel_of(input logic signed [INT_W-1:0] cc);
    logic signed [INT_W-1:0] s;
    s = BIAS_W + cc;
    if (s > FS_MAX)      s = FS_MAX;
    else if (s < FS_MIN) s = FS_MIN;
    return DCO_CC_WIDTH'(s);
  endfunction

  // A strobe is taken only in an active (non-IDLE) state with the node enabled
  assign accept_c = update_i && enable_i && (state_q != ST_IDLE);

  // Stage 1 datapath: full-precision weighted sum, arithmetic shift, saturate
  always_comb begin
    sum_c = '0;
    err_k = '0;
    wgt_k = '0;
    for (int k = 0; k < int'(NUM_NEIGHBOURS); k++) begin
      err_k = $signed(errors_i[k*ERROR_WIDTH +: ERROR_WIDTH]);
      wgt_k = $signed(SUM_W'({1'b0, weights_i[k*WEIGHT_WIDTH +: WEIGHT_WIDTH]}));
      sum_c = sum_c + SUM_W'(err_k) * wgt_k;
    end
    shift_c = sum_c >>> (WEIGHT_WIDTH - 1);
    if (shift_c > ERR_MAX)      comb_c = ERROR_WIDTH'(ERR_MAX);
    else if (shift_c < ERR_MIN) comb_c = ERROR_WIDTH'(ERR_MIN);
    else                        comb_c = ERROR_WIDTH'(shift_c);
  end

  // Stage 1 registers: combined error plus the controls that travel with the strobe
  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      s1_valid_q   <= 1'b0;
      s1_mode_q    <= '0;
      s1_kp_q      <= '0;
      s1_ki_q      <= '0;
      s1_man_q     <= '0;
      error_comb_q <= '0;
    end else begin
      s1_valid_q <= accept_c;
      if (accept_c) begin
        s1_mode_q    <= mode_i;
        s1_kp_q      <= kp_i;
        s1_ki_q      <= ki_i;
        s1_man_q     <= $signed(manual_cc_i);
        error_comb_q <= comb_c;
      end
    end
  end

  // Next-state and stage 2 datapath: PI filter, mode handling, lock detection
  always_comb begin
    state_d   = state_q;
    integ_d   = integ_q;
    cnt_d     = cnt_q;
    dco_d     = dco_q;
    fsel_d    = fsel_q;
    locked_d  = locked_q;
    valid_d   = 1'b0;

    e_w       = INT_W'(error_comb_q);
    integ_sum = INT_W'(integ_q) + e_w * $signed(INT_W'({1'b0, s1_ki_q}));
    if (integ_sum > ACC_MAX)      integ_new = ACC_MAX;
    else if (integ_sum < ACC_MIN) integ_new = ACC_MIN;
    else                          integ_new = integ_sum;
    out_w     = e_w * $signed(INT_W'({1'b0, s1_kp_q})) + integ_new;
    out_sh    = out_w >>> FRAC_WIDTH;
    if (out_sh > DCO_MAX)      dco_w = DCO_MAX;
    else if (out_sh < DCO_MIN) dco_w = DCO_MIN;
    else                       dco_w = out_sh;
    man_w     = INT_W'(s1_man_q);

    e_ext     = ABS_W'(error_comb_q);
    abs_e     = e_ext[ABS_W-1] ? ABS_W'(-e_ext) : ABS_W'(e_ext);
    if (abs_e <= TH_IN) cnt_n = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    else                cnt_n = '0;

    if (!enable_i || (state_q == ST_IDLE)) begin
      // IDLE holds everything at reset values except the combined error
      state_d  = enable_i ? ST_ACQUIRE : ST_IDLE;
      integ_d  = '0;
      cnt_d    = '0;
      dco_d    = '0;
      fsel_d   = DCO_CC_WIDTH'(BIAS);
      locked_d = 1'b0;
    end else if (s1_valid_q) begin
      valid_d = 1'b1;
      case (s1_mode_q)
        2'b00: begin
          integ_d = ACC_WIDTH'(integ_new);
          dco_d   = DCO_CC_WIDTH'(dco_w);
          fsel_d  = fsel_of(dco_w);
          cnt_d   = cnt_n;
          if (state_q == ST_LOCKED)
            state_d = (abs_e > TH_OUT) ? ST_ACQUIRE : ST_LOCKED;
          else
            state_d = (cnt_n == CNT_MAX) ? ST_LOCKED : ST_ACQUIRE;
          locked_d = (state_d == ST_LOCKED);
        end
        2'b01: begin
          // Preload the integrator so returning to closed loop is bumpless
          state_d  = ST_MANUAL;
          integ_d  = ACC_WIDTH'(man_w <<< FRAC_WIDTH);
          dco_d    = s1_man_q;
          fsel_d   = fsel_of(man_w);
          cnt_d    = '0;
          locked_d = 1'b0;
        end
        default: state_d = ST_HOLD;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Stage 2 registers and loop-filter state
  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      integ_q  <= '0;
      cnt_q    <= '0;
      dco_q    <= '0;
      fsel_q   <= DCO_CC_WIDTH'(BIAS);
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      integ_q  <= integ_d;
      cnt_q    <= cnt_d;
      dco_q    <= dco_d;
      fsel_q   <= fsel_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
    end
  end

  assign error_comb_o = error_comb_q;
  assign dco_cc_o     = dco_q;
  assign f_sel_o      = fsel_q;
  assign valid_o      = valid_q;
  assign locked_o     = locked_q;

endmodule

// File: tb/tb_pll_node_ctrl.sv
// Testbench for pll_node_ctrl: directed vector table, corner-case sequences
// and a randomized phase checked against a transaction-level reference model.
module tb_pll_node_ctrl;

  localparam int N = 4, EW = 5, WW = 4, KPW = 6, KIW = 8, CCW = 5;

  logic            clk = 1'b0;
  logic            rst, en, upd;
  logic [N*EW-1:0] errs;
  logic [N*WW-1:0] wts;
  logic [KPW-1:0]  kp;
  logic [KIW-1:0]  ki;
  logic [1:0]      mode;
  logic [CCW-1:0]  man;
  logic [EW-1:0]   ec_o;
  logic [CCW-1:0]  dco_o, fsel_o;
  logic            valid_o, locked_o;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state (0 idle, 1 acquire, 2 locked, 3 manual, 4 hold)
  int     m_st, m_cnt, m_ec, m_dco, m_fsel, m_valid, m_locked;
  longint m_integ;
  int     p_v, p_e, p_mode, p_kp, p_ki, p_man;

  pll_node_ctrl dut (
    .fpga_clk_i  (clk),
    .reset_i     (rst),
    .enable_i    (en),
    .update_i    (upd),
    .errors_i    (errs),
    .weights_i   (wts),
    .kp_i        (kp),
    .ki_i        (ki),
    .mode_i      (mode),
    .manual_cc_i (man),
    .error_comb_o(ec_o),
    .dco_cc_o    (dco_o),
    .f_sel_o     (fsel_o),
    .valid_o     (valid_o),
    .locked_o    (locked_o)
  );

  always #5 clk = ~clk;

  function automatic longint clampl(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // One accepted update, evaluated directly from the arithmetic rules
  task automatic model_step();
    int st_old, ek, wk, sum;
    longint e, tmp;
    st_old = m_st;
    if (rst) begin
      m_st = 0; m_integ = 0; m_cnt = 0; m_ec = 0; m_dco = 0;
      m_fsel = 15; m_valid = 0; m_locked = 0; p_v = 0;
      return;
    end
    m_valid = 0;
    if (!en || st_old == 0) begin
      m_st = en ? 1 : 0;
      m_integ = 0; m_cnt = 0; m_dco = 0; m_fsel = 15; m_locked = 0;
    end else if (p_v != 0) begin
      m_valid = 1;
      if (p_mode == 1) begin
        m_st = 3; m_dco = p_man; m_integ = p_man * 32; m_cnt = 0; m_locked = 0;
        m_fsel = int'(clampl(15 + p_man, 0, 31));
      end else if (p_mode >= 2) begin
        m_st = 4;
      end else begin
        e = p_e;
        m_integ = clampl(m_integ + e * p_ki, -32767, 32767);
        tmp = (e * p_kp + m_integ) >>> 5;
        m_dco = int'(clampl(tmp, -16, 15));
        m_fsel = int'(clampl(15 + m_dco, 0, 31));
        m_cnt = ((p_e <= 1) && (p_e >= -1)) ? ((m_cnt < 16) ? m_cnt + 1 : 16) : 0;
        if (st_old == 2) m_st = ((p_e > 2) || (p_e < -2)) ? 1 : 2;
        else             m_st = (m_cnt == 16) ? 2 : 1;
        m_locked = (m_st == 2) ? 1 : 0;
      end
    end
    p_v = 0;
    if (en && st_old != 0 && upd) begin
      sum = 0;
      for (int k = 0; k < N; k++) begin
        ek = int'($signed(errs[k*EW +: EW]));
        wk = int'(wts[k*WW +: WW]);
        sum += ek * wk;
      end
      m_ec = int'(clampl(sum >>> 3, -16, 15));
      p_v = 1; p_e = m_ec; p_mode = int'(mode);
      p_kp = int'(kp); p_ki = int'(ki); p_man = int'($signed(man));
    end
  endtask

  // Advance one clock; the model steps on the edge, outputs settle by negedge
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_model(input int c);
    n_checks++;
    if (int'($signed(ec_o)) != m_ec || int'($signed(dco_o)) != m_dco ||
        int'(fsel_o) != m_fsel || int'(valid_o) != m_valid || int'(locked_o) != m_locked) begin
      n_err++;
      $display("FAIL model cycle %0d got ec=%0d dco=%0d fsel=%0d v=%0d lk=%0d expected ec=%0d dco=%0d fsel=%0d v=%0d lk=%0d",
               c, $signed(ec_o), $signed(dco_o), fsel_o, valid_o, locked_o,
               m_ec, m_dco, m_fsel, m_valid, m_locked);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; upd = 1'b0; mode = 2'b00;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
  endtask

  // Isolated strobe: returns the combined error seen at T+1, leaves bench at T+2
  task automatic strobe(output int ec_t1, output int v_t1);
    upd = 1'b1;
    cyc();
    ec_t1 = int'($signed(ec_o));
    v_t1  = int'(valid_o);
    upd = 1'b0;
    cyc();
  endtask

  typedef struct {
    logic [N*WW-1:0] w;
    logic [N*EW-1:0] e;
    logic [KPW-1:0]  kp;
    int              exp_ec;
    int              exp_dco;
    int              exp_fsel;
  } vec_t;

  vec_t vt[7];
  int   ec1, v1;
  int   r;
  bit   quiet;

  initial begin
    vt[0] = '{16'h0088, {5'h10, 5'h10, 5'd5,  5'd3 }, 6'd4,  8,   1,  16};
    vt[1] = '{16'hFFFF, {5'd15, 5'd15, 5'd15, 5'd15}, 6'd63, 15,  15, 30};
    vt[2] = '{16'hFFFF, {5'h10, 5'h10, 5'h10, 5'h10}, 6'd63, -16, -16, 0};
    vt[3] = '{16'h0001, {15'd0, 5'h1F},               6'd32, -1,  -1, 14};
    vt[4] = '{16'h4444, {5'd1,  5'd1,  5'd1,  5'd1 }, 6'd16, 2,   1,  16};
    vt[5] = '{16'h00F8, {10'd0, 5'h1E, 5'h19},        6'd3,  -11, -2, 13};
    vt[6] = '{16'h8800, {5'd6,  5'd7,  10'd0},        6'd10, 13,  4,  19};

    rst = 1'b1; en = 1'b0; upd = 1'b0; errs = '0; wts = '0;
    kp = '0; ki = '0; mode = 2'b00; man = '0;
    m_st = 0; m_integ = 0; m_cnt = 0; m_ec = 0; m_dco = 0; m_fsel = 15;
    m_valid = 0; m_locked = 0; p_v = 0;

    // Reset values
    do_reset();
    chk("rst_ec", int'($signed(ec_o)), 0);
    chk("rst_dco", int'($signed(dco_o)), 0);
    chk("rst_fsel", int'(fsel_o), 15);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_locked", int'(locked_o), 0);

    // Combiner / proportional table
    for (int i = 0; i < 7; i++) begin
      wts = vt[i].w; errs = vt[i].e; kp = vt[i].kp; ki = '0;
      strobe(ec1, v1);
      chk($sformatf("tbl%0d_ec", i), ec1, vt[i].exp_ec);
      chk($sformatf("tbl%0d_v_t1", i), v1, 0);
      chk($sformatf("tbl%0d_valid", i), int'(valid_o), 1);
      chk($sformatf("tbl%0d_dco", i), int'($signed(dco_o)), vt[i].exp_dco);
      chk($sformatf("tbl%0d_fsel", i), int'(fsel_o), vt[i].exp_fsel);
    end

    // Integral path with back-to-back strobes
    do_reset();
    kp = '0; ki = 8'd1; wts = 16'h0008; errs = {15'd0, 5'd4};
    for (int c = 1; c <= 10; c++) begin
      upd = (c <= 8);
      cyc();
      if (c >= 2 && c <= 9) begin
        chk($sformatf("integ_valid%0d", c - 1), int'(valid_o), 1);
        chk($sformatf("integ_dco%0d", c - 1), int'($signed(dco_o)), ((c - 1) == 8) ? 1 : 0);
      end
      if (c == 9) chk("integ_fsel", int'(fsel_o), 16);
      if (c == 10) chk("integ_valid_end", int'(valid_o), 0);
    end

    // Lock acquisition and loss
    do_reset();
    kp = '0; ki = '0; wts = 16'h0008; errs = '0;
    for (int i = 0; i < 16; i++) begin
      strobe(ec1, v1);
      chk($sformatf("lock_%0d", i), int'(locked_o), (i == 15) ? 1 : 0);
    end
    errs = {15'd0, 5'd2};
    strobe(ec1, v1);
    chk("lock_err2", int'(locked_o), 1);
    errs = {15'd0, 5'd3};
    strobe(ec1, v1);
    chk("lock_err3_ec", ec1, 3);
    chk("lock_err3", int'(locked_o), 0);

    // Manual and bumpless return
    mode = 2'b01; man = 5'h1C;
    strobe(ec1, v1);
    chk("man_dco", int'($signed(dco_o)), -4);
    chk("man_fsel", int'(fsel_o), 11);
    mode = 2'b00; errs = '0; kp = 6'd9;
    strobe(ec1, v1);
    chk("bump_dco", int'($signed(dco_o)), -4);
    chk("bump_fsel", int'(fsel_o), 11);

    // Hold freezes the loop but still reports
    mode = 2'b10; ki = 8'd5; errs = {15'd0, 5'd5};
    for (int i = 0; i < 3; i++) begin
      strobe(ec1, v1);
      chk($sformatf("hold_ec%0d", i), ec1, 5);
      chk($sformatf("hold_valid%0d", i), int'(valid_o), 1);
      chk($sformatf("hold_dco%0d", i), int'($signed(dco_o)), -4);
    end

    // Reset in the middle of a strobe stream
    mode = 2'b00; upd = 1'b1;
    cyc();
    rst = 1'b1;
    cyc();
    chk("mrst_ec", int'($signed(ec_o)), 0);
    chk("mrst_dco", int'($signed(dco_o)), 0);
    chk("mrst_fsel", int'(fsel_o), 15);
    chk("mrst_valid", int'(valid_o), 0);
    chk("mrst_locked", int'(locked_o), 0);
    rst = 1'b0; upd = 1'b0;
    cyc(); chk("mrst_valid2", int'(valid_o), 0);
    cyc(); chk("mrst_valid3", int'(valid_o), 0);

    // Strobe coincident with IDLE exit is ignored
    en = 1'b0;
    cyc();
    en = 1'b1; upd = 1'b1;
    cyc();
    upd = 1'b0;
    cyc(); chk("idle_exit_v1", int'(valid_o), 0);
    cyc(); chk("idle_exit_v2", int'(valid_o), 0);

    // Enable drop discards an in-flight strobe
    upd = 1'b1;
    cyc();
    en = 1'b0; upd = 1'b0;
    cyc();
    chk("endrop_valid", int'(valid_o), 0);
    chk("endrop_dco", int'($signed(dco_o)), 0);
    en = 1'b1;
    cyc();

    // Randomized phase against the reference model
    quiet = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) begin
        quiet = ($urandom_range(0, 1) == 1);
        kp = KPW'($urandom);
        ki = quiet ? KIW'($urandom_range(0, 3)) : KIW'($urandom);
      end
      if ($urandom_range(0, 29) == 0) begin
        r = int'($urandom_range(0, 8));
        mode = (r == 6) ? 2'b01 : (r == 7) ? 2'b10 : (r == 8) ? 2'b11 : 2'b00;
      end
      for (int k = 0; k < N; k++) begin
        if (quiet) begin
          wts[k*WW +: WW]  = 4'd8;
          errs[k*EW +: EW] = EW'(int'($urandom_range(0, 2)) - 1);
        end else begin
          wts[k*WW +: WW]  = WW'($urandom);
          errs[k*EW +: EW] = EW'($urandom);
        end
      end
      man = CCW'($urandom);
      upd = quiet ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 2) == 0);
      en  = ($urandom_range(0, 149) != 0);
      rst = ($urandom_range(0, 599) == 0);
      cyc();
      chk_model(c);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pll_node_ctrl.md
Name: pll_node_ctrl

Overview:
- Digital control core of one ADPLL network node, generalised to NUM_NEIGHBOURS phase-error channels.
- Combines the neighbour errors using weights, runs a PI loop filter and produces the DCO control code plus the biased ring-oscillator frequency select.
- Adds operating modes (closed-loop, manual, hold) and a lock detector.
- Sits between the per-neighbour phase detectors and the ring oscillator. Processing runs on fpga_clk_i and is paced by a one-cycle update strobe, one per divided generated-clock period.

Parameters:
- NUM_NEIGHBOURS, 4, number of error/weight channels.
- ERROR_WIDTH, 5, signed phase-error width.
- WEIGHT_WIDTH, 4, unsigned weight width; weight 2^(WEIGHT_WIDTH-1) is unity gain.
- KP_WIDTH, 6, unsigned proportional gain width.
- KI_WIDTH, 8, unsigned integral gain width.
- FRAC_WIDTH, 5, fractional bits of the PI path.
- ACC_WIDTH, 16, signed integrator width.
- DCO_CC_WIDTH, 5, signed DCO control-code width.
- BIAS, 15, unsigned offset added to the DCO code to form the frequency select.
- LOCK_THRESH, 1, lock window on |error_comb|.
- LOCK_COUNT, 16, consecutive in-window updates required to declare lock.

Ports:
- fpga_clk_i  in  1  single system clock.
- reset_i  in  1  synchronous, active-high reset.
- enable_i  in  1  node enable; low forces IDLE.
- update_i  in  1  one-cycle strobe, already synchronised to fpga_clk_i.
- errors_i  in  NUM_NEIGHBOURS*ERROR_WIDTH  signed errors; channel k occupies bits [k*ERROR_WIDTH +: ERROR_WIDTH].
- weights_i  in  NUM_NEIGHBOURS*WEIGHT_WIDTH  unsigned weights, packed the same way.
- kp_i  in  KP_WIDTH  proportional gain.
- ki_i  in  KI_WIDTH  integral gain.
- mode_i  in  2  00 closed-loop, 01 manual, 10/11 hold.
- manual_cc_i  in  DCO_CC_WIDTH  signed code used in manual mode.
- error_comb_o  out  ERROR_WIDTH  signed combined error (registered).
- dco_cc_o  out  DCO_CC_WIDTH  signed DCO control code.
- f_sel_o  out  DCO_CC_WIDTH  unsigned ring-oscillator frequency select.
- valid_o  out  1  one-cycle pulse when dco_cc_o/f_sel_o update.
- locked_o  out  1  lock indicator.

Behaviour:
- Reset values (synchronous, reset_i has priority over all inputs):
  - error_comb_o=0, dco_cc_o=0, f_sel_o=BIAS, valid_o=0, locked_o=0.
  - Integrator=0, lock counter=0, FSM=IDLE.
- Pipeline: update_i accepted in cycle T.
  - Stage 1 (T+1): error_comb_o = sat_ERROR_WIDTH((sum over k of weights[k]*errors[k]) >>> (WEIGHT_WIDTH-1)). Arithmetic shift; full-precision sum before the shift. Weight 0 disconnects a channel.
  - Stage 2 (T+2): dco_cc_o, f_sel_o and locked_o update; valid_o pulses high for one cycle.
- Fully pipelined: strobes in consecutive cycles are each processed. mode_i is sampled with the strobe and travels down the pipeline with it.
- PI, closed-loop:
  - integ_next = sat_ACC(integ + e*ki_i).
  - out = (e*kp_i + integ_next) >>> FRAC_WIDTH.
  - dco_cc_o = sat_DCO_CC_WIDTH(out).
  - All intermediate arithmetic is signed and wide enough to avoid overflow before saturation.
- Frequency select: f_sel_o = clamp(BIAS + dco_cc_o, 0, 2^DCO_CC_WIDTH-1).
- Manual mode:
  - dco_cc_o = manual_cc_i.
  - Integrator preloaded with manual_cc_i << FRAC_WIDTH (sign-extended), so return to closed-loop is bumpless.
  - Lock detector is cleared.
- Hold mode: integrator, dco_cc_o, f_sel_o, lock counter and locked_o are all frozen. error_comb_o still updates. valid_o still pulses.
- FSM states: IDLE, ACQUIRE, LOCKED, MANUAL, HOLD.
  - IDLE -> ACQUIRE when enable_i=1.
  - Any state -> IDLE when enable_i=0. IDLE applies reset values, except error_comb_o, which holds its last value.
  - Strobes in IDLE are ignored: no valid_o. A strobe already in flight when enable_i falls is discarded.
  - ACQUIRE/LOCKED -> MANUAL on mode 01; -> HOLD on mode 1x.
  - MANUAL/HOLD -> ACQUIRE on mode 00. Leaving HOLD restores nothing.
  - ACQUIRE -> LOCKED when the lock counter reaches LOCK_COUNT.
  - LOCKED -> ACQUIRE on any update with |error_comb| > 2*LOCK_THRESH.
- Lock counter, closed-loop only:
  - Increments (saturating at LOCK_COUNT) per update with |error_comb| <= LOCK_THRESH; otherwise cleared.
  - locked_o = (state==LOCKED), registered at T+2.
- Boundaries:
  - Integrator clamps at ±(2^(ACC_WIDTH-1)-1); the most negative value is never produced.
  - Output saturation does not stop integration.
  - Reset mid-pipeline discards in-flight data.
  - enable_i and update_i high together in the same cycle as the IDLE exit: that strobe is ignored.

Test Plan:
- Combiner: weights {8,8,0,0}, errors {+3,+5,-16,-16}, one strobe -> error_comb_o=8 at T+1, valid_o at T+2.
- Saturation: all weights 15, all errors +15 -> sum 900>>>3=112 -> error_comb_o=15. kp=63, ki=0 -> dco_cc_o=+15, f_sel_o=30.
- Integral: kp=0, ki=1, combined error 4, 8 strobes -> integ=32; dco_cc_o steps 0,0,...,1 on the 8th output; f_sel_o=16.
- Lock: errors 0, closed-loop, 16 strobes -> locked_o=0 after 15 strobes, 1 at T+2 of the 16th. Then combined error 3 -> locked_o=0 on that output.
- Manual/bumpless: mode 01, manual_cc_i=-4 -> dco_cc_o=-4, f_sel_o=11. Switch to mode 00 with error 0, kp=9 -> dco_cc_o stays -4.
- Reset/hold: mode 1x with nonzero errors -> dco_cc_o constant, valid_o pulses. reset_i asserted mid-stream -> reset values next cycle and no valid_o for in-flight strobes.
